// File: rtl/instruction_ram.sv
// instruction_ram: byte-loaded instruction memory with registered fetch port.
// A loader streams bytes MSB-first; every ceil(DATA_WIDTH/8) accepted bytes form
// one word written at the next free location. Fetches return NOP_WORD while a
// load is in progress or when the address is beyond the array.
// Optional feature: define IMEM_CHECKSUM_EN to get a running XOR of written words
// on oChecksum; otherwise oChecksum is tied to zero.
module instruction_ram #(
  parameter int                    DATA_WIDTH = 28,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [15:0]           iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  input  logic                  iLoadStart,
  input  logic [7:0]            iLoadByte,
  input  logic                  iLoadValid,
  input  logic                  iLoadEnd,
  output logic                  oLoadReady,
  output logic                  oLoadDone,
  output logic                  oOverflow,
  output logic [ADDR_WIDTH:0]   oWordCount,
  output logic [DATA_WIDTH-1:0] oChecksum
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BPW   = (DATA_WIDTH + 7) / 8;
  localparam int ASM_W = BPW * 8;
  localparam int BCW   = $clog2(BPW + 1);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [BCW-1:0]        r_bcnt;
  logic [ADDR_WIDTH:0]   r_wcount;
  logic                  r_overflow;
  logic                  r_done;
  logic [ASM_W-1:0]      r_asm;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_end;
  logic                  w_word_done;
  logic                  w_has_room;
  logic                  w_wr_en;
  logic                  w_in_range;
  logic [ASM_W-1:0]      w_asm_next;
  logic [DATA_WIDTH-1:0] w_word;

  // Next-state logic and loader handshake decode; a start pulse masks byte and end.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iLoadStart) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_accept = iLoadValid && !iLoadStart;
        w_end    = iLoadEnd && !iLoadStart;
        if (iLoadStart)    w_state_next = S_LOAD;
        else if (iLoadEnd) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The final byte of a word is merged combinationally so the write happens on that same edge.
  assign w_asm_next  = ASM_W'({r_asm, iLoadByte});
  assign w_word      = w_asm_next[DATA_WIDTH-1:0];
  assign w_word_done = w_accept && (r_bcnt == BCW'(BPW - 1));
  assign w_has_room  = (r_wcount < (ADDR_WIDTH + 1)'(DEPTH));
  assign w_wr_en     = w_word_done && w_has_room && !Reset;
  assign w_in_range  = ({16'd0, iAddress} < DEPTH);

  // Control state: FSM, byte counter, word count (also the write pointer), flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_wcount   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_end;
      if (iLoadStart) begin
        r_bcnt     <= '0;
        r_wcount   <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        if (w_word_done) begin
          r_bcnt <= '0;
          if (w_has_room) r_wcount   <= r_wcount + (ADDR_WIDTH + 1)'(1);
          else            r_overflow <= 1'b1;
        end else begin
          r_bcnt <= r_bcnt + BCW'(1);
        end
      end
      if (w_end) r_bcnt <= '0;
    end
  end

  // Byte assembly shift register; stale bits are fully shifted out by the next word.
  always_ff @(posedge Clock) begin
    if (w_accept) r_asm <= w_asm_next;
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge Clock) begin
    if (w_wr_en) r_mem[r_wcount[ADDR_WIDTH-1:0]] <= w_word;
  end

  // Registered fetch; NOP while loading (including the cycle entering LOAD) or out of range.
  always_ff @(posedge Clock) begin
    if (Reset)
      r_instr <= NOP_WORD;
    else if ((w_state_next == S_LOAD) || !w_in_range)
      r_instr <= NOP_WORD;
    else
      r_instr <= r_mem[iAddress[ADDR_WIDTH-1:0]];
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Running XOR of every word committed since the last start or reset.
  always_ff @(posedge Clock) begin
    if (Reset || iLoadStart) r_checksum <= '0;
    else if (w_wr_en)        r_checksum <= r_checksum ^ w_word;
  end

  assign oChecksum = r_checksum;
`else
  assign oChecksum = '0;
`endif

  assign oInstruction = r_instr;
  assign oLoadReady   = (r_state == S_LOAD);
  assign oLoadDone    = r_done;
  assign oOverflow    = r_overflow;
  assign oWordCount   = r_wcount;

endmodule
